// File: rtl/frame_sync_deframer_if.sv
// frame_sync_deframer_if: the CDR-side bit stream, the output FIFO write
// port and the per-frame status of the deframer, bundled as one port.
//
// Handshake: inBit is consumed on every cycle that inBitValid is high.
// There is no ready, so the deframer always accepts. outNibble is written to
// the FIFO on every cycle that outNibbleValid is high. inFifoFull is only
// looked at on the cycle a nibble completes, and a full FIFO drops that nibble.
//
// dbgState exposes the deframer FSM state (0 HUNT, 1 LEN, 2 PAYLOAD).
interface frame_sync_deframer_if;
    logic       inBit;
    logic       inBitValid;
    logic       inFifoFull;
    logic [3:0] outNibble;
    logic       outNibbleValid;
    logic       outFrameStart;
    logic [6:0] outLength;
    logic       outFrameEnd;
    logic       outFrameError;
    logic       outFcsOk;
    logic       outBusy;
    logic [1:0] dbgState;

    // master: the CDR/FIFO side that feeds the deframer
    modport master (
        output inBit, inBitValid, inFifoFull,
        input  outNibble, outNibbleValid, outFrameStart, outLength,
        input  outFrameEnd, outFrameError, outFcsOk, outBusy, dbgState
    );

    // slave: the deframer itself
    modport slave (
        input  inBit, inBitValid, inFifoFull,
        output outNibble, outNibbleValid, outFrameStart, outLength,
        output outFrameEnd, outFrameError, outFcsOk, outBusy, dbgState
    );
endinterface

// File: rtl/frame_sync_deframer.sv
// frame_sync_deframer: hunts for a zero preamble plus SFD in the recovered
// bit stream, then reads the PHR length byte. It repacks the payload into
// 4-bit nibbles for the output FIFO and reports frame start, end and error.
//
// Optional build macro FRAME_SYNC_FCS_CHECK_EN adds a bit-serial
// CRC-16/KERMIT check over the payload, including the trailing FCS bytes.
// It also makes lengths below 3 illegal. Without the macro, outFcsOk is
// tied high.
module frame_sync_deframer #(
    parameter logic [7:0] SFD_PATTERN    = 8'hA7,
    parameter int         PREAMBLE_MIN   = 16,
    parameter int         MAX_LEN        = 127,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  inClock,
    input  logic                  inReset,
    frame_sync_deframer_if.slave  bus
);

    localparam int         IW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] TO_CNT = IW'(TIMEOUT_CYCLES);
    localparam logic [7:0] PRE_MIN   = 8'(PREAMBLE_MIN);
    localparam logic [6:0] MAX_L     = 7'(MAX_LEN);
`ifdef FRAME_SYNC_FCS_CHECK_EN
    localparam logic [6:0] MIN_L     = 7'd3;
`else
    localparam logic [6:0] MIN_L     = 7'd1;
`endif

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [7:0]    zrun_q, zrun_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]    nib_q, nib_d;
    logic [1:0]    nib_cnt_q, nib_cnt_d;
    logic          byte_half_q, byte_half_d;
    logic [6:0]    byte_cnt_q, byte_cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    out_nibble_q, out_nibble_d;
    logic          out_nibble_valid_q, out_nibble_valid_d;
    logic          out_frame_start_q, out_frame_start_d;
    logic [6:0]    out_length_q, out_length_d;
    logic          out_frame_end_q, out_frame_end_d;
    logic          out_frame_error_q, out_frame_error_d;
    logic          out_busy_q, out_busy_d;
`ifdef FRAME_SYNC_FCS_CHECK_EN
    logic [15:0]   crc_q, crc_d;
    logic [15:0]   crc_step;
    logic          out_fcs_ok_q, out_fcs_ok_d;
`endif

    // Combinational helpers shared by the next-state logic
    logic [7:0] sr_shift;
    logic [7:0] zrun_inc;
    logic [3:0] nibble_full;
    logic [6:0] len_l;
    logic       ovf_acc;
    logic       fcs_bad;

    // Next-state and registered-output computation for the deframer FSM
    always_comb begin
        state_d            = state_q;
        sr_d               = sr_q;
        zrun_d             = zrun_q;
        bit_cnt_d          = bit_cnt_q;
        nib_d              = nib_q;
        nib_cnt_d          = nib_cnt_q;
        byte_half_d        = byte_half_q;
        byte_cnt_d         = byte_cnt_q;
        idle_d             = '0;
        ovf_d              = ovf_q;
        out_nibble_d       = out_nibble_q;
        out_nibble_valid_d = 1'b0;
        out_frame_start_d  = 1'b0;
        out_length_d       = out_length_q;
        out_frame_end_d    = 1'b0;
        out_frame_error_d  = 1'b0;
        ovf_acc            = ovf_q;
        fcs_bad            = 1'b0;
`ifdef FRAME_SYNC_FCS_CHECK_EN
        crc_d        = crc_q;
        out_fcs_ok_d = out_fcs_ok_q;
        crc_step     = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ bus.inBit) ? 16'h8408 : 16'h0000);
`endif

        sr_shift    = {bus.inBit, sr_q[7:1]};
        zrun_inc    = sr_q[0] ? 8'd0 : ((zrun_q == 8'hFF) ? 8'hFF : zrun_q + 8'd1);
        nibble_full = {bus.inBit, nib_q[3:1]};
        len_l       = sr_shift[6:0];

        // The shift register follows every accepted bit. The LEN state
        // reuses it to collect the length byte.
        if (bus.inBitValid) begin
            sr_d = sr_shift;
        end

        // Idle counter runs only while a frame is open. A bit always clears
        // it, so a bit arriving on the timeout cycle wins.
        if (state_q != ST_HUNT) begin
            idle_d = bus.inBitValid ? '0 : idle_q + 1'b1;
        end

        case (state_q)
            ST_HUNT: begin
                if (bus.inBitValid) begin
                    zrun_d = zrun_inc;
                    if (sr_shift == SFD_PATTERN && zrun_inc >= PRE_MIN) begin
                        state_d   = ST_LEN;
                        bit_cnt_d = 3'd0;
                        sr_d      = 8'hFF;
                        zrun_d    = 8'd0;
                    end
                end
            end

            ST_LEN: begin
                if (bus.inBitValid) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        // Bit 7 of the length byte is reserved and ignored
                        if (len_l >= MIN_L && len_l <= MAX_L) begin
                            state_d           = ST_PAYLOAD;
                            out_length_d      = len_l;
                            out_frame_start_d = 1'b1;
                            nib_cnt_d         = 2'd0;
                            byte_half_d       = 1'b0;
                            byte_cnt_d        = 7'd0;
                            ovf_d             = 1'b0;
`ifdef FRAME_SYNC_FCS_CHECK_EN
                            crc_d             = 16'h0000;
`endif
                        end else begin
                            state_d           = ST_HUNT;
                            out_frame_error_d = 1'b1;
                        end
                    end
                end else if (idle_d == TO_CNT) begin
                    state_d           = ST_HUNT;
                    out_frame_error_d = 1'b1;
                end
            end

            ST_PAYLOAD: begin
                if (bus.inBitValid) begin
                    nib_d     = nibble_full;
                    nib_cnt_d = nib_cnt_q + 2'd1;
`ifdef FRAME_SYNC_FCS_CHECK_EN
                    crc_d     = crc_step;
                    fcs_bad   = (crc_step != 16'h0000);
`endif
                    if (nib_cnt_q == 2'd3) begin
                        if (!bus.inFifoFull) begin
                            out_nibble_d       = nibble_full;
                            out_nibble_valid_d = 1'b1;
                        end else begin
                            ovf_acc = 1'b1;
                        end
                        ovf_d       = ovf_acc;
                        byte_half_d = ~byte_half_q;
                        if (byte_half_q) begin
                            byte_cnt_d = byte_cnt_q + 7'd1;
                            if ({1'b0, byte_cnt_q} + 8'd1 == {1'b0, out_length_q}) begin
                                state_d           = ST_HUNT;
                                out_frame_end_d   = 1'b1;
                                out_frame_error_d = ovf_acc | fcs_bad;
                                ovf_d             = 1'b0;
`ifdef FRAME_SYNC_FCS_CHECK_EN
                                out_fcs_ok_d      = ~fcs_bad;
`endif
                            end
                        end
                    end
                end else if (idle_d == TO_CNT) begin
                    // Abort: any partial nibble is simply abandoned
                    state_d           = ST_HUNT;
                    out_frame_end_d   = 1'b1;
                    out_frame_error_d = 1'b1;
                    ovf_d             = 1'b0;
`ifdef FRAME_SYNC_FCS_CHECK_EN
                    out_fcs_ok_d      = 1'b0;
`endif
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase

        out_busy_d = (state_d != ST_HUNT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge inClock) begin
        if (inReset) begin
            state_q            <= ST_HUNT;
            sr_q               <= 8'hFF;
            zrun_q             <= 8'd0;
            bit_cnt_q          <= 3'd0;
            nib_q              <= 4'd0;
            nib_cnt_q          <= 2'd0;
            byte_half_q        <= 1'b0;
            byte_cnt_q         <= 7'd0;
            idle_q             <= '0;
            ovf_q              <= 1'b0;
            out_nibble_q       <= 4'd0;
            out_nibble_valid_q <= 1'b0;
            out_frame_start_q  <= 1'b0;
            out_length_q       <= 7'd0;
            out_frame_end_q    <= 1'b0;
            out_frame_error_q  <= 1'b0;
            out_busy_q         <= 1'b0;
`ifdef FRAME_SYNC_FCS_CHECK_EN
            crc_q              <= 16'h0000;
            out_fcs_ok_q       <= 1'b0;
`endif
        end else begin
            state_q            <= state_d;
            sr_q               <= sr_d;
            zrun_q             <= zrun_d;
            bit_cnt_q          <= bit_cnt_d;
            nib_q              <= nib_d;
            nib_cnt_q          <= nib_cnt_d;
            byte_half_q        <= byte_half_d;
            byte_cnt_q         <= byte_cnt_d;
            idle_q             <= idle_d;
            ovf_q              <= ovf_d;
            out_nibble_q       <= out_nibble_d;
            out_nibble_valid_q <= out_nibble_valid_d;
            out_frame_start_q  <= out_frame_start_d;
            out_length_q       <= out_length_d;
            out_frame_end_q    <= out_frame_end_d;
            out_frame_error_q  <= out_frame_error_d;
            out_busy_q         <= out_busy_d;
`ifdef FRAME_SYNC_FCS_CHECK_EN
            crc_q              <= crc_d;
            out_fcs_ok_q       <= out_fcs_ok_d;
`endif
        end
    end

    assign bus.outNibble      = out_nibble_q;
    assign bus.outNibbleValid = out_nibble_valid_q;
    assign bus.outFrameStart  = out_frame_start_q;
    assign bus.outLength      = out_length_q;
    assign bus.outFrameEnd    = out_frame_end_q;
    assign bus.outFrameError  = out_frame_error_q;
    assign bus.outBusy        = out_busy_q;
    assign bus.dbgState       = state_q;
`ifdef FRAME_SYNC_FCS_CHECK_EN
    assign bus.outFcsOk       = out_fcs_ok_q;
`else
    assign bus.outFcsOk       = 1'b1;
`endif

endmodule

// File: doc/frame_sync_deframer.md
Name: frame_sync_deframer

Overview:
- Receive-side deframer directly downstream of the clock/data recovery (CDR) stage.
- Consumes the recovered bit stream, one bit per CDR flag strobe.
- Hunts for an 802.15.4-style zero preamble followed by the SFD, then extracts the PHR length byte.
- Repacks payload bits into 4-bit nibbles with a write strobe for the 4-bit output FIFO, plus per-frame start/end/error status.

Parameters:
- SFD_PATTERN, 8'hA7: start-of-frame delimiter, compared LSB-first.
- PREAMBLE_MIN, 16: minimum consecutive zero bits required immediately before the SFD.
- MAX_LEN, 127: largest legal payload length in bytes.
- TIMEOUT_CYCLES, 1024: clock cycles without inBitValid that abort a frame in LEN or PAYLOAD.

Ports:
- inClock  in  1  system clock.
- inReset  in  1  synchronous, active-high reset.
- inBit  in  1  recovered bit (CDR data).
- inBitValid  in  1  one-cycle strobe; inBit is sampled when high (CDR flag).
- inFifoFull  in  1  output FIFO full.
- outNibble  out  4  payload nibble.
- outNibbleValid  out  1  one-cycle write strobe for outNibble.
- outFrameStart  out  1  one-cycle pulse: valid length accepted.
- outLength  out  7  accepted payload length in bytes; held until the next accepted length.
- outFrameEnd  out  1  one-cycle pulse: frame finished or aborted in PAYLOAD.
- outFrameError  out  1  one-cycle pulse: frame faulty.
- outFcsOk  out  1  FCS status, valid when outFrameEnd is high.
- outBusy  out  1  high in any state other than HUNT.

Behaviour:
- Clocking and reset: one clock, inClock; reset inReset is synchronous and active-high.
- Reset state: state=HUNT, shift register sr=8'hFF, all counters 0, all outputs 0 (outLength=0).
- Reset mid-frame: a partial nibble is discarded and no end or error pulse is produced.
- All outputs are registered. A bit sampled at cycle N produces its effect at cycle N+1.
- Bits arrive LSB-first. On each inBitValid: sr <= {inBit, sr[7:1]}. The bit leaving sr[0] updates zrun: +1 (saturating at 255) if 0, cleared if 1.
- HUNT:
  - Go to LEN when sr (after shift) == SFD_PATTERN and zrun >= PREAMBLE_MIN.
  - On entering LEN: bit counter cleared, sr reloaded with 8'hFF, zrun cleared.
- LEN:
  - Collect 8 bits LSB-first into lenByte. Bit 7 is reserved and ignored; L = lenByte[6:0].
  - On the 8th bit, if 1 <= L <= MAX_LEN: go to PAYLOAD, outLength <= L, outFrameStart pulse.
  - Otherwise: outFrameError pulse alone (no start, no end), return to HUNT.
- PAYLOAD:
  - Accumulate 4 bits, bit0 first into outNibble[0].
  - On the 4th bit: if !inFifoFull, pulse outNibbleValid; else drop the nibble and set sticky ovf.
  - Byte counter counts to L. On the last bit of byte L: outFrameEnd pulses in the same cycle as the final nibble strobe, outFrameError = ovf | fcsBad. Then return to HUNT and clear ovf.
- Timeout:
  - An idle counter resets on each inBitValid and increments otherwise, in LEN and PAYLOAD only.
  - Reaching TIMEOUT_CYCLES in LEN: outFrameError pulse, go to HUNT.
  - Reaching it in PAYLOAD: outFrameEnd and outFrameError pulse together, go to HUNT. The partial nibble is discarded.
- Simultaneous events: inBitValid in the same cycle the timeout count is reached takes priority; the bit is accepted and the counter is cleared.
- Back-to-back frames: HUNT restarts on the cycle after outFrameEnd. The payload of the previous frame never satisfies the preamble check because zrun is cleared at SFD.
- inFifoFull is only sampled on nibble-completion cycles.

Optional Feature:
- Macro: FRAME_SYNC_FCS_CHECK_EN.
- Defined:
  - CRC-16/KERMIT (reflected polynomial 0x8408, init 0x0000) runs bit-serially over every payload bit, including the final 2 FCS bytes.
  - Residue 0 at the end gives outFcsOk=1; nonzero gives outFcsOk=0 and fcsBad=1.
  - L < 3 is treated as an illegal length in LEN.
- Undefined: no CRC logic, outFcsOk tied to 1, fcsBad=0.

Test Plan:
- Good frame:
  - Stimulus: 32 zeros, SFD 0xA7 LSB-first, length 0x03, payload 0x21 0x43 0x65, inBitValid every 4 cycles.
  - Response: outFrameStart with outLength=3; nibbles 1,2,3,4,5,6; outFrameEnd with the 6th nibble; outFrameError=0.
- Short preamble: 8 zeros then SFD and a valid frame -> no outFrameStart, no nibbles, outBusy stays 0.
- Bad length (two cases):
  - Length 0x00 after a valid SFD -> outFrameError pulse, no outFrameStart, back to HUNT.
  - Length 0x80 (L=0) -> same response.
- Overflow: same as the good frame with inFifoFull=1 during the 3rd nibble -> 5 nibble strobes; outFrameEnd with outFrameError=1.
- Timeout: stop inBitValid after 2 payload bytes for 1024 cycles -> outFrameEnd and outFrameError together, outBusy=0 next cycle. A following good frame is received correctly.
- FCS (macro defined): payload 0x31 0x32 0x33 plus the correct CRC-16/KERMIT FCS bytes (LSB first), length 5 -> outFcsOk=1, outFrameError=0. Flip one payload bit -> outFcsOk=0, outFrameError=1.
- Reset mid-frame: inReset asserted for 1 cycle during PAYLOAD -> all outputs 0 next cycle, no end pulse; a subsequent good frame is received.
